// File: rtl/wisc_pkg.sv
// Shared types for the 16-bit pipeline memory stage: widths, MEM FSM states,
// the MEM/WB record layout and the accepted-instruction hold record.
package wisc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] Result;
        logic [REG_AW-1:0] WriteReg;
        logic              RegWrite;
        logic              halt;
        logic              err;
    } wb_rec_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [REG_AW-1:0] write_reg;
        logic              mem_read;
        logic              reg_write;
        logic              halt;
    } hold_t;

    // A memory op is rejected when it is both read and write or word-misaligned.
    function automatic logic bad_access(input logic addr_lsb, input logic rd, input logic wr);
        return (rd & wr) | ((rd | wr) & addr_lsb);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the data memory; expired marks the last
// permitted cycle of a MAX_WAIT-cycle request window.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: accepts EX results, runs the Done-handshake data memory access,
// and retires exactly one registered MEM/WB record per accepted instruction.
module mem_stage_ctrl
    import wisc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_ALUOut,
    input  logic [DATA_W-1:0] ex_StoreData,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_RegWrite,
    input  logic [REG_AW-1:0] ex_WriteReg,
    input  logic              ex_halt,
    output logic [DATA_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_DataIn,
    output logic              mem_Rd,
    output logic              mem_Wr,
    input  logic [DATA_W-1:0] mem_DataOut,
    input  logic              mem_Done,
    input  logic              mem_Stall,
    input  logic              mem_err,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_Result,
    output logic [REG_AW-1:0] wb_WriteReg,
    output logic              wb_RegWrite,
    output logic              wb_halt,
    output logic              wb_err
);

    mem_state_t state;
    hold_t      hold;
    wb_rec_t    wb;
    logic       accept;
    logic       is_mem;
    logic       bad;
    logic       tmr_expired;
    logic       unused_stall;

    // Done is authoritative; the busy indication carries no extra information here.
    assign unused_stall = mem_Stall;

    // wb.halt doubles as the sticky halted flag: once set, nothing is accepted again.
    assign ex_ready = (state == IDLE) && !wb.halt;
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_MemRead | ex_MemWrite;
    assign bad      = bad_access(ex_ALUOut[0], ex_MemRead, ex_MemWrite);

    function automatic wb_rec_t make_rec(
        input logic [DATA_W-1:0] res,
        input logic [REG_AW-1:0] wreg,
        input logic              regw,
        input logic              hlt,
        input logic              err
    );
        wb_rec_t r;
        r.Result   = res;
        r.WriteReg = wreg;
        r.RegWrite = regw & ~err;
        r.halt     = hlt | err;
        r.err      = err;
        return r;
    endfunction

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (state != IDLE),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            wb         <= '0;
            wb_valid   <= 1'b0;
            mem_Rd     <= 1'b0;
            mem_Wr     <= 1'b0;
            mem_Addr   <= '0;
            mem_DataIn <= '0;
        end else begin
            wb_valid <= 1'b0;
            mem_Rd   <= 1'b0;
            mem_Wr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold <= '{alu_out:   ex_ALUOut,
                                  write_reg: ex_WriteReg,
                                  mem_read:  ex_MemRead,
                                  reg_write: ex_RegWrite,
                                  halt:      ex_halt};
                        if (is_mem && !bad) begin
                            state      <= REQ;
                            mem_Rd     <= ex_MemRead;
                            mem_Wr     <= ex_MemWrite;
                            mem_Addr   <= ex_ALUOut;
                            mem_DataIn <= ex_StoreData;
                        end else begin
                            // Plain ALU ops and rejected memory ops retire next cycle.
                            wb_valid <= 1'b1;
                            wb       <= make_rec(ex_ALUOut, ex_WriteReg, ex_RegWrite,
                                                 ex_halt, bad);
                        end
                    end
                end
                REQ, WAIT: begin
                    if (mem_Done) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb       <= make_rec(hold.mem_read ? mem_DataOut : hold.alu_out,
                                             hold.write_reg, hold.reg_write, hold.halt,
                                             mem_err);
                    end else if (tmr_expired) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb       <= make_rec(hold.alu_out, hold.write_reg, hold.reg_write,
                                             hold.halt, 1'b1);
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_Result   = wb.Result;
    assign wb_WriteReg = wb.WriteReg;
    assign wb_RegWrite = wb.RegWrite;
    assign wb_halt     = wb.halt;
    assign wb_err      = wb.err;

endmodule
